// File: rtl/mem_match_scoreboard.sv
// Turn and score engine for the N-player card-matching game: pairs picks into turns,
// credits matches, rotates the active player on a miss, and ranks players at game end.
module mem_match_scoreboard #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_PAIRS   = 8,
  parameter int SYM_W       = 4,
  localparam int PW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int SCW        = $clog2(NUM_PAIRS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       new_game,
  input  logic                       pick_valid,
  input  logic                       pick_empty,
  input  logic [SYM_W-1:0]           pick_sym,
  output logic [PW-1:0]              cur_player,
  output logic                       second_pick,
  output logic                       match_pulse,
  output logic                       miss_pulse,
  output logic [NUM_PLAYERS*SCW-1:0] scores,
  output logic [SCW-1:0]             pairs_found,
  output logic                       game_over,
  output logic [PW-1:0]              winner,
  output logic                       tie
);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    SCAN   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [PW-1:0]  LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [SCW-1:0] LAST_PAIR   = SCW'(NUM_PAIRS - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SYM_W-1:0] sym1_r;
  logic [PW-1:0]    cur_player_r;
  logic [SCW-1:0]   score_r [NUM_PLAYERS];
  logic [SCW-1:0]   pairs_r;
  logic             match_r;
  logic             miss_r;
  logic [PW-1:0]    scan_idx_r;
  logic [SCW-1:0]   max_r;
  logic [PW-1:0]    best_r;
  logic             tie_r;

  logic             accept_s;
  logic             hit_s;
  logic             miss_s;
  logic             last_pair_s;
  logic             scan_last_s;
  logic [SCW-1:0]   scan_score_s;

  assign accept_s    = pick_valid & pick_empty & ((state_r == FIRST) | (state_r == SECOND));
  assign last_pair_s = (pairs_r == LAST_PAIR);
  assign scan_last_s = (scan_idx_r == LAST_PLAYER);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FIRST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and turn-outcome decode; new_game overrides any same-cycle pick
  always_comb begin
    state_nxt_s = state_r;
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    if (new_game) begin
      state_nxt_s = FIRST;
    end else begin
      case (state_r)
        FIRST: begin
          if (accept_s) state_nxt_s = SECOND;
          else          state_nxt_s = FIRST;
        end
        SECOND: begin
          if (!accept_s) begin
            state_nxt_s = SECOND;
          end else if (pick_sym == sym1_r) begin
            hit_s       = 1'b1;
            state_nxt_s = last_pair_s ? SCAN : FIRST;
          end else begin
            miss_s      = 1'b1;
            state_nxt_s = FIRST;
          end
        end
        SCAN:    state_nxt_s = scan_last_s ? DONE : SCAN;
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = FIRST;
      endcase
    end
  end

  // Score of the player currently being ranked
  always_comb begin
    scan_score_s = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      scan_score_s = (scan_idx_r == PW'(p)) ? score_r[p] : scan_score_s;
    end
  end

  // Turn datapath, scores and ranking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym1_r       <= '0;
      cur_player_r <= '0;
      pairs_r      <= '0;
      match_r      <= 1'b0;
      miss_r       <= 1'b0;
      scan_idx_r   <= '0;
      max_r        <= '0;
      best_r       <= '0;
      tie_r        <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_r[p] <= '0;
    end else if (new_game) begin
      sym1_r       <= '0;
      cur_player_r <= '0;
      pairs_r      <= '0;
      match_r      <= 1'b0;
      miss_r       <= 1'b0;
      scan_idx_r   <= '0;
      max_r        <= '0;
      best_r       <= '0;
      tie_r        <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_r[p] <= '0;
    end else begin
      match_r <= hit_s;
      miss_r  <= miss_s;
      if (accept_s && (state_r == FIRST)) sym1_r <= pick_sym;
      if (hit_s) pairs_r <= pairs_r + SCW'(1);
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (hit_s && (cur_player_r == PW'(p))) score_r[p] <= score_r[p] + SCW'(1);
      end
      if (miss_s) cur_player_r <= (cur_player_r == LAST_PLAYER) ? '0 : cur_player_r + PW'(1);
      // Strict > keeps the lowest index; an equal later score only raises tie
      if (state_r == SCAN) begin
        if (!scan_last_s) scan_idx_r <= scan_idx_r + PW'(1);
        if (scan_idx_r == '0) begin
          max_r  <= scan_score_s;
          best_r <= '0;
          tie_r  <= 1'b0;
        end else if (scan_score_s > max_r) begin
          max_r  <= scan_score_s;
          best_r <= scan_idx_r;
          tie_r  <= 1'b0;
        end else if (scan_score_s == max_r) begin
          tie_r  <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
    assign scores[g*SCW +: SCW] = score_r[g];
  end

  assign cur_player  = cur_player_r;
  assign second_pick = (state_r == SECOND);
  assign match_pulse = match_r;
  assign miss_pulse  = miss_r;
  assign pairs_found = pairs_r;
  assign game_over   = (state_r == DONE);
  assign winner      = game_over ? best_r : '0;
  assign tie         = game_over & tie_r;

endmodule

// File: tb/tb_mem_match_scoreboard.sv
// Scoreboard bench: a 2-player and a 3-player instance; expected turn outcomes are
// queued when a second pick is driven and compared when the DUT pulses.
module tb_mem_match_scoreboard;

  logic        clk_s = 1'b0;
  logic        rst_s = 1'b1;

  logic        a_new_game_s = 1'b0, a_pick_valid_s = 1'b0, a_pick_empty_s = 1'b0;
  logic [3:0]  a_pick_sym_s = 4'd0;
  logic [0:0]  a_cur_player_s, a_winner_s;
  logic        a_second_pick_s, a_match_s, a_miss_s, a_game_over_s, a_tie_s;
  logic [7:0]  a_scores_s;
  logic [3:0]  a_pairs_s;

  logic        b_new_game_s = 1'b0, b_pick_valid_s = 1'b0, b_pick_empty_s = 1'b0;
  logic [3:0]  b_pick_sym_s = 4'd0;
  logic [1:0]  b_cur_player_s, b_winner_s;
  logic        b_second_pick_s, b_match_s, b_miss_s, b_game_over_s, b_tie_s;
  logic [11:0] b_scores_s;
  logic [3:0]  b_pairs_s;

  typedef struct {
    int d;
    bit match;
    int pidx;
    int score;
    int pairs;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_cur[2];
  int   m_score[2][3];
  int   m_pairs[2];
  bit   m_done[2];
  int   cyc;

  always #5 clk_s = ~clk_s;

  mem_match_scoreboard #(.NUM_PLAYERS(2), .NUM_PAIRS(8), .SYM_W(4)) u_dut_a (
    .clk(clk_s), .rst(rst_s), .new_game(a_new_game_s), .pick_valid(a_pick_valid_s),
    .pick_empty(a_pick_empty_s), .pick_sym(a_pick_sym_s), .cur_player(a_cur_player_s),
    .second_pick(a_second_pick_s), .match_pulse(a_match_s), .miss_pulse(a_miss_s),
    .scores(a_scores_s), .pairs_found(a_pairs_s), .game_over(a_game_over_s),
    .winner(a_winner_s), .tie(a_tie_s)
  );

  mem_match_scoreboard #(.NUM_PLAYERS(3), .NUM_PAIRS(8), .SYM_W(4)) u_dut_b (
    .clk(clk_s), .rst(rst_s), .new_game(b_new_game_s), .pick_valid(b_pick_valid_s),
    .pick_empty(b_pick_empty_s), .pick_sym(b_pick_sym_s), .cur_player(b_cur_player_s),
    .second_pick(b_second_pick_s), .match_pulse(b_match_s), .miss_pulse(b_miss_s),
    .scores(b_scores_s), .pairs_found(b_pairs_s), .game_over(b_game_over_s),
    .winner(b_winner_s), .tie(b_tie_s)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear(input int d);
    m_cur[d] = 0; m_pairs[d] = 0; m_done[d] = 1'b0;
    for (int p = 0; p < 3; p++) m_score[d][p] = 0;
  endtask

  task automatic pick(input int d, input logic v, input logic e, input logic [3:0] s);
    @(posedge clk_s); #1;
    if (d == 0) begin a_pick_valid_s = v; a_pick_empty_s = e; a_pick_sym_s = s; end
    else        begin b_pick_valid_s = v; b_pick_empty_s = e; b_pick_sym_s = s; end
    @(posedge clk_s); #1;
    a_pick_valid_s = 1'b0; a_pick_empty_s = 1'b0;
    b_pick_valid_s = 1'b0; b_pick_empty_s = 1'b0;
  endtask

  task automatic turn(input int d, input logic [3:0] s1, input logic [3:0] s2);
    int np;
    exp_t e;
    np = (d == 0) ? 2 : 3;
    pick(d, 1'b1, 1'b1, s1);
    check_val("second_pick_after_first", (d == 0) ? a_second_pick_s : b_second_pick_s,
              m_done[d] ? 32'd0 : 32'd1);
    if (!m_done[d]) begin
      if (s1 == s2) begin
        m_score[d][m_cur[d]]++;
        m_pairs[d]++;
        if (m_pairs[d] == 8) m_done[d] = 1'b1;
        e.match = 1'b1;
      end else begin
        m_cur[d] = (m_cur[d] == np - 1) ? 0 : m_cur[d] + 1;
        e.match = 1'b0;
      end
      e.d = d; e.pidx = m_cur[d]; e.score = m_score[d][m_cur[d]]; e.pairs = m_pairs[d];
      q_exp.push_back(e);
    end
    pick(d, 1'b1, 1'b1, s2);
    @(negedge clk_s); #1;
    check_val("pulse_consumed", q_exp.size(), 0);
  endtask

  task automatic mon(input int d);
    exp_t e;
    logic m, x;
    logic [3:0] sc, pf;
    logic [1:0] cp;
    m  = (d == 0) ? a_match_s : b_match_s;
    x  = (d == 0) ? a_miss_s : b_miss_s;
    cp = (d == 0) ? {1'b0, a_cur_player_s} : b_cur_player_s;
    pf = (d == 0) ? a_pairs_s : b_pairs_s;
    check_val("pulse_exclusive", m & x, 0);
    if (q_exp.size() == 0) begin
      check_val("stray_pulse", 1, 0);
    end else begin
      e  = q_exp.pop_front();
      sc = (d == 0) ? a_scores_s[e.pidx*4 +: 4] : b_scores_s[e.pidx*4 +: 4];
      check_val("pulse_dut", d, e.d);
      check_val("match_pulse", m, e.match);
      check_val("miss_pulse", x, !e.match);
      check_val("cur_player", cp, e.pidx);
      check_val("player_score", sc, e.score);
      check_val("pairs_found", pf, e.pairs);
    end
  endtask

  // Outcome monitor: every pulse must match the oldest queued expectation
  always @(negedge clk_s) begin
    if (a_match_s || a_miss_s) mon(0);
    if (b_match_s || b_miss_s) mon(1);
  end

  task automatic wait_game_over(input int d, input int exp_lat);
    cyc = 0;
    while (((d == 0) ? a_game_over_s : b_game_over_s) == 1'b0 && cyc < 12) begin
      @(posedge clk_s); #1;
      cyc++;
      if (((d == 0) ? a_game_over_s : b_game_over_s) == 1'b0)
        check_val("result_zero_before_done",
                  (d == 0) ? {a_winner_s, a_tie_s} : {b_winner_s, b_tie_s}, 0);
    end
    check_val("game_over_latency", cyc, exp_lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clk_s);
    #1 rst_s = 1'b0;
    @(negedge clk_s);
    check_val("rst_cur_player", a_cur_player_s, 0);
    check_val("rst_second_pick", a_second_pick_s, 0);
    check_val("rst_pulses", {a_match_s, a_miss_s}, 0);
    check_val("rst_scores", a_scores_s, 0);
    check_val("rst_pairs", a_pairs_s, 0);
    check_val("rst_result", {a_game_over_s, a_winner_s, a_tie_s}, 0);
    check_val("rst_b_scores", b_scores_s, 0);

    // Illegal picks are ignored
    pick(0, 1'b1, 1'b0, 4'd3);
    check_val("occupied_pick_ignored", a_second_pick_s, 0);
    pick(0, 1'b0, 1'b1, 4'd3);
    check_val("invalid_pick_ignored", a_second_pick_s, 0);

    turn(0, 4'd3, 4'd3);
    check_val("match_keeps_turn", a_cur_player_s, 0);
    turn(0, 4'd1, 4'd2);
    check_val("miss_advances", a_cur_player_s, 1);
    turn(0, 4'd3, 4'd5);
    check_val("miss_wraps", a_cur_player_s, 0);

    // Full game: P0 ends on 5 pairs, P1 on 3
    repeat (4) turn(0, 4'd4, 4'd4);
    turn(0, 4'd6, 4'd7);
    turn(0, 4'd2, 4'd2);
    turn(0, 4'd8, 4'd8);
    turn(0, 4'd9, 4'd9);
    wait_game_over(0, 2);
    check_val("a_game_over", a_game_over_s, 1);
    check_val("a_winner", a_winner_s, 0);
    check_val("a_tie", a_tie_s, 0);
    check_val("a_final_scores", a_scores_s, 8'h35);
    check_val("a_final_pairs", a_pairs_s, 8);
    turn(0, 4'd1, 4'd1);
    check_val("done_ignores_picks", a_scores_s, 8'h35);

    // new_game beats a same-cycle pick
    @(posedge clk_s); #1;
    a_new_game_s = 1'b1; a_pick_valid_s = 1'b1; a_pick_empty_s = 1'b1; a_pick_sym_s = 4'd7;
    @(posedge clk_s); #1;
    a_new_game_s = 1'b0; a_pick_valid_s = 1'b0; a_pick_empty_s = 1'b0;
    model_clear(0);
    check_val("ng_second_pick", a_second_pick_s, 0);
    check_val("ng_scores", a_scores_s, 0);
    check_val("ng_result", {a_game_over_s, a_winner_s, a_tie_s, a_pairs_s}, 0);

    // new_game mid-turn drops the latched card
    pick(0, 1'b1, 1'b1, 4'd5);
    check_val("midturn_second_pick", a_second_pick_s, 1);
    @(posedge clk_s); #1 a_new_game_s = 1'b1;
    @(posedge clk_s); #1 a_new_game_s = 1'b0;
    check_val("ng_midturn_second_pick", a_second_pick_s, 0);
    turn(0, 4'd6, 4'd6);

    // 3 players ending 3/3/2: tie, lowest index wins
    repeat (3) turn(1, 4'd1, 4'd1);
    turn(1, 4'd2, 4'd3);
    repeat (3) turn(1, 4'd4, 4'd4);
    turn(1, 4'd5, 4'd6);
    turn(1, 4'd7, 4'd7);
    turn(1, 4'd8, 4'd8);
    wait_game_over(1, 3);
    check_val("b_winner", b_winner_s, 0);
    check_val("b_tie", b_tie_s, 1);
    check_val("b_scores", b_scores_s, 12'h233);
    turn(1, 4'd2, 4'd2);
    check_val("b_done_ignores", b_scores_s, 12'h233);

    // Async reset mid-turn
    pick(0, 1'b1, 1'b1, 4'd3);
    check_val("pre_rst_second_pick", a_second_pick_s, 1);
    @(posedge clk_s); #1 rst_s = 1'b1;
    #2;
    check_val("async_rst_second_pick", a_second_pick_s, 0);
    check_val("async_rst_b_game_over", b_game_over_s, 0);
    @(posedge clk_s); #1 rst_s = 1'b0;
    model_clear(0);
    model_clear(1);
    pick(0, 1'b1, 1'b1, 4'd4);
    check_val("post_rst_second_pick", a_second_pick_s, 1);
    check_val("post_rst_scores", a_scores_s, 0);

    repeat (2) @(negedge clk_s);
    check_val("queue_empty", q_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
